// File: rtl/fb_pkg.sv
// fb_pkg: shared types, default sizes and helpers for the frame-buffer colour mapper.
// Pixel colour is carried as rgb_t {r,g,b}; the palette resets to a greyscale ramp.
package fb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int MEM_LAT_DEF = 2;

  // Frame-buffer row length in stored pixels.
  function automatic int fb_width(input int h_res, input int shift);
    return h_res >> shift;
  endfunction

  // Grey level for palette entry idx: top 8 index bits, or the index
  // itself zero-extended when the index is narrower than 8 bits.
  function automatic rgb_t grey_rgb(input int idx, input int idx_w);
    int   v;
    rgb_t c;
    if (idx_w >= 8) v = idx >> (idx_w - 8);
    else            v = idx;
    c.r = v[7:0];
    c.g = v[7:0];
    c.b = v[7:0];
    return c;
  endfunction

endpackage

// File: rtl/fb_color_mapper_palette_ram.sv
// palette_ram: 2^IDX_W x rgb_t colour table, one sync read port, one write port.
// Read-first on same-index collisions; the read register loads a fill colour when disabled.
module palette_ram
  import fb_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  rgb_t             wdata_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] raddr_i,
  input  rgb_t             fill_i,
  output rgb_t             rdata_o
);

  localparam int DEPTH = 1 << IDX_W;

  rgb_t mem_q [DEPTH];
  rgb_t rdata_q;

  // Table storage: greyscale ramp on reset, otherwise write port updates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= grey_rgb(i, IDX_W);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: old table contents (read-first) or the fill colour.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= fill_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_color_mapper.sv
// fb_color_mapper: DrawX/DrawY -> frame-buffer address -> palette -> VGA RGB.
// Optional FB_BORDER_COLOR_EN adds border_rgb for pixels outside the visible area.
module fb_color_mapper
  import fb_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int SCALE_SHIFT = 0,
  parameter int ADDR_W      = 19,
  parameter int IDX_W       = 8,
  parameter int MEM_LAT     = MEM_LAT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] read_address,
  input  logic [IDX_W-1:0]  fb_index,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [23:0]       pal_wdata,
`ifdef FB_BORDER_COLOR_EN
  input  logic [23:0]       border_rgb,
`endif
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  localparam int FB_W = fb_width(H_RES, SCALE_SHIFT);
  localparam logic [9:0] SUB_MASK = 10'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        prev_y_q;
  logic              in_bounds;
  logic [MEM_LAT:0]  vld_q;
  rgb_t              fill;
  rgb_t              pix;

  assign in_bounds = (32'(DrawX) < H_RES) && (32'(DrawY) < V_RES);

  // Next line base: restart at row 0, step one stored row on each new
  // source row that begins a replicated block.
  always_comb begin
    line_base_d = line_base_q;
    if (DrawY == '0) begin
      line_base_d = '0;
    end else if ((DrawY != prev_y_q) && ((DrawY & SUB_MASK) == '0)) begin
      line_base_d = line_base_q + FB_W_A;
    end
  end

  // Next read address uses the updated base so a new line's first pixel
  // is correct; off-screen pixels leave the address where it was.
  always_comb begin
    addr_d = addr_q;
    if (in_bounds) begin
      addr_d = line_base_d + ADDR_W'(DrawX >> SCALE_SHIFT);
    end
  end

  // Address stage registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      line_base_q <= '0;
      addr_q      <= '0;
      prev_y_q    <= '0;
    end else begin
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
      prev_y_q    <= DrawY;
    end
  end

  // in_bounds tracks each access through the memory latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[MEM_LAT-1:0], in_bounds};
    end
  end

`ifdef FB_BORDER_COLOR_EN
  rgb_t bord_q [MEM_LAT+1];

  // Border colour follows off-screen pixels down the same pipeline.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i <= MEM_LAT; i++) begin
        bord_q[i] <= '0;
      end
    end else begin
      bord_q[0] <= in_bounds ? rgb_t'(24'h0) : rgb_t'(border_rgb);
      for (int i = 1; i <= MEM_LAT; i++) begin
        bord_q[i] <= bord_q[i-1];
      end
    end
  end

  assign fill = bord_q[MEM_LAT];
`else
  assign fill = '0;
`endif

  palette_ram #(
    .IDX_W (IDX_W)
  ) u_pal (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (rgb_t'(pal_wdata)),
    .rd_en_i (vld_q[MEM_LAT]),
    .raddr_i (fb_index),
    .fill_i  (fill),
    .rdata_o (pix)
  );

  assign read_address = addr_q;
  assign VGA_R        = pix.r;
  assign VGA_G        = pix.g;
  assign VGA_B        = pix.b;

endmodule

// File: tb/tb_fb_color_mapper.sv
// tb_fb_color_mapper: directed vectors for the colour mapper, default and 2x scaled.
// Frame buffer modelled as index = read_address[7:0] with two cycles of latency.
module tb_fb_color_mapper;
  import fb_pkg::*;

  typedef struct {
    int          x;
    int          y;
    bit          we;
    logic [7:0]  wa;
    logic [23:0] wd;
    bit          c0;
    logic [18:0] a0;
    bit          c1;
    logic [18:0] a1;
    logic [23:0] rgb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  dx, dy;
  logic [18:0] ra0, ra1;
  logic [7:0]  fbi0, fbi1, d1, d2;
  logic        we;
  logic [7:0]  wa;
  logic [23:0] wd;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
`ifdef FB_BORDER_COLOR_EN
  logic [23:0] border = 24'h0000FF;
  localparam logic [23:0] OOB_RGB = 24'h0000FF;
`else
  localparam logic [23:0] OOB_RGB = 24'h000000;
`endif

  int checks   = 0;
  int failures = 0;
  logic [23:0] expq[$];
  vec_t tbl[$];
  vec_t tbl_post[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= ra0[7:0];
    d2 <= d1;
  end
  assign fbi0 = d2;
  assign fbi1 = 8'h00;

  fb_color_mapper u0 (
    .Clk(clk), .Reset(rst), .DrawX(dx), .DrawY(dy),
    .read_address(ra0), .fb_index(fbi0),
    .pal_we(we), .pal_addr(wa), .pal_wdata(wd),
`ifdef FB_BORDER_COLOR_EN
    .border_rgb(border),
`endif
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0)
  );

  fb_color_mapper #(.SCALE_SHIFT(1)) u1 (
    .Clk(clk), .Reset(rst), .DrawX(dx), .DrawY(dy),
    .read_address(ra1), .fb_index(fbi1),
    .pal_we(we), .pal_addr(wa), .pal_wdata(wd),
`ifdef FB_BORDER_COLOR_EN
    .border_rgb(border),
`endif
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t pix(input int x, input int y);
    vec_t v;
    int   a;
    a     = y * 640 + x;
    v.x   = x;
    v.y   = y;
    v.we  = 1'b0;
    v.wa  = 8'h00;
    v.wd  = 24'h0;
    v.c0  = 1'b1;
    v.a0  = 19'(a);
    v.c1  = 1'b1;
    v.a1  = 19'((y >> 1) * 320 + (x >> 1));
    v.rgb = {3{a[7:0]}};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    dx = v.x[9:0];
    dy = v.y[9:0];
    we = v.we;
    wa = v.wa;
    wd = v.wd;
    expq.push_back(v.rgb);
    @(posedge clk);
    #1;
    we = 1'b0;
    if (v.c0) chk($sformatf("addr x=%0d y=%0d", v.x, v.y), ra0, v.a0);
    if (v.c1) chk($sformatf("addr_s1 x=%0d y=%0d", v.x, v.y), ra1, v.a1);
    chk("rgb", {r0, g0, b0}, expq.pop_front());
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_addr", ra0, 0);
    chk("rst_addr_s1", ra1, 0);
    chk("rst_rgb", {r0, g0, b0}, 0);
    expq.delete();
    repeat (3) expq.push_back(24'h0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    dx  = '0;
    dy  = '0;
    we  = 1'b0;
    wa  = '0;
    wd  = '0;

    for (int x = 0; x < 640; x++) tbl.push_back(pix(x, 0));
    tbl.push_back(pix(0, 1));
    tbl.push_back(pix(1, 1));
    tbl.push_back(pix(0, 2));
    tbl.push_back(pix(16, 2));
    tbl.push_back(pix(17, 2));
    tbl.push_back(pix(18, 2));
    v    = pix(19, 2);
    v.we = 1'b1;
    v.wa = 8'h10;
    v.wd = 24'hFF8000;
    tbl.push_back(v);
    v     = pix(272, 2);
    v.rgb = 24'hFF8000;
    tbl.push_back(v);
    tbl.push_back(pix(20, 2));
    tbl.push_back(pix(5, 3));
    for (int y = 4; y <= 10; y++) tbl.push_back(pix(0, y));
    v     = pix(700, 10);
    v.a0  = 19'd6400;
    v.a1  = 19'd1600;
    v.rgb = OOB_RGB;
    tbl.push_back(v);
    v.x   = 701;
    tbl.push_back(v);
    tbl.push_back(pix(298, 10));
    tbl.push_back(pix(299, 10));
    tbl.push_back(pix(300, 10));

    for (int x = 16; x <= 22; x++) tbl_post.push_back(pix(x, 0));

    do_reset(2);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    do_reset(1);
    for (int i = 0; i < tbl_post.size(); i++) apply(tbl_post[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_color_mapper.md
Name: fb_color_mapper

Overview:
- Parametrised successor to the lab-8 colour mapper.
- Generates frame-buffer read addresses from DrawX/DrawY without a runtime multiplier, supporting integer pixel scaling (2^SCALE_SHIFT).
- Aligns the returned palette index with the memory read latency and resolves it through a run-time-writable RGB palette.
- Sits between the VGA controller, the on-chip/SRAM frame buffer, and the VGA DAC pins.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines per frame.
- SCALE_SHIFT, 0, log2 of the pixel replication factor; frame buffer is (H_RES>>SCALE_SHIFT) x (V_RES>>SCALE_SHIFT).
- ADDR_W, 19, frame-buffer address width.
- IDX_W, 8, palette index width; the palette has 2^IDX_W entries.
- MEM_LAT, 2, cycles from read_address to a valid fb_index (>=1).

Ports:
- Clk  in  1  system/pixel clock.
- Reset  in  1  synchronous, active-high.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row from the VGA controller.
- read_address  out  ADDR_W  frame-buffer read address.
- fb_index  in  IDX_W  palette index returned by the frame buffer, MEM_LAT cycles after read_address.
- pal_we  in  1  palette write strobe.
- pal_addr  in  IDX_W  palette write index.
- pal_wdata  in  24  {R,G,B} palette write data.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.

Behaviour:
- Reset behaviour:
  - read_address, VGA_R, VGA_G and VGA_B reset to 0.
  - The line-base accumulator and all pipeline valid bits clear.
  - Palette entry i resets to {i[IDX_W-1 -: 8] zero-extended, same, same}, i.e. a greyscale ramp.
- Address generation (stage A, registered):
  - FB_W = H_RES>>SCALE_SHIFT.
  - The line_base register holds (DrawY>>SCALE_SHIFT)*FB_W, maintained incrementally:
    - DrawY==0: line_base <= 0.
    - Otherwise, when DrawY differs from its previous-cycle value and DrawY[SCALE_SHIFT-1:0]==0: line_base <= line_base + FB_W.
  - read_address <= line_base_next + (DrawX>>SCALE_SHIFT), where line_base_next is the value line_base takes on this same edge. The first pixel of a new line therefore already uses the updated base.
  - Out-of-bounds pixels (DrawX>=H_RES or DrawY>=V_RES): read_address holds its previous value and in_bounds=0 enters the pipeline.
  - Arithmetic is unsigned and truncated to ADDR_W. The default sizes fit in 19 bits (307199 max).
- Alignment:
  - An in_bounds shift register of depth 1+MEM_LAT travels alongside the memory access.
  - fb_index is sampled when the delayed in_bounds reaches the palette stage.
- Palette stage (registered):
  - The palette read is synchronous, one cycle.
  - Output registers load the palette entry if the delayed in_bounds=1, else 24'h000000.
  - Total latency from DrawX/DrawY to VGA_R/G/B = 2 + MEM_LAT cycles (4 at default).
- Palette writes:
  - Accepted any cycle, including active video.
  - An entry written on edge N is visible to reads from edge N+1.
  - A simultaneous read and write of the same index returns the old data (read-first).
- Reset mid-frame: the pipeline flushes, and outputs are black until 2+MEM_LAT cycles after Reset deasserts. Palette contents return to the greyscale ramp.
- DrawX/DrawY are trusted to advance monotonically within a frame. No error detection.

Optional Feature:
- Macro: FB_BORDER_COLOR_EN.
- Defined:
  - Adds input border_rgb[23:0].
  - Out-of-bounds pixels output border_rgb, registered through the same pipeline, with the same latency.
- Undefined: out-of-bounds pixels are 24'h000000 and the port is absent.

Decomposition:
- Package fb_pkg:
  - rgb_t packed struct {r,g,b} 8 bits each.
  - Default constants H_RES_DEF, V_RES_DEF, MEM_LAT_DEF.
  - Function fb_width(h_res, shift).
- Sub-module palette_ram:
  - 2^IDX_W x rgb_t, with one synchronous read port and one write port.
  - Read-first behaviour and greyscale reset.
  - Instantiated once.

Test Plan:
- Reset, then sweep DrawX 0..639 on DrawY=0 with fb_index=read_address[7:0] modelled, MEM_LAT=2:
  - read_address = x one cycle after DrawX.
  - VGA_R=G=B=x[7:0] four cycles after DrawX.
- DrawY steps 0->1->2 at DrawX=0:
  - read_address = 640 and 1280 on the first pixel of each line.
  - No stale-base pixel.
- SCALE_SHIFT=1, DrawY=3, DrawX=5:
  - read_address = 1*320+2 = 322.
  - DrawY=4 gives base 640.
- Write pal_addr=8'h10, pal_wdata=24'hFF8000 while index 8'h10 is being read in the same cycle:
  - That pixel outputs 101010.
  - The next pixel with index 10 outputs FF8000.
- DrawX=700, DrawY=10:
  - Output 000000 after 4 cycles; read_address is unchanged.
  - With FB_BORDER_COLOR_EN and border_rgb=24'h0000FF, output 0000FF.
- Assert Reset for 1 cycle mid-line at DrawX=300:
  - Outputs 0 for 4 cycles after release.
  - Palette entry 8'h10 reads back 101010.
